// File: rtl/model_loader.sv
// Framed host-link byte loader: decodes SYNC/TYPE/payload/CHECK frames and writes the
// image, conv and dense memories of the inference core, pulsing start after a good image.
module model_loader #(
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter int         IMG_BYTES     = 784,
  parameter int         CONV_W_BYTES  = 36,
  parameter int         CONV_B_WORDS  = 4,
  parameter int         DENSE_W_BYTES = 27040,
  parameter int         DENSE_B_WORDS = 10,
  parameter bit         AUTO_START    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        infer_busy,
  output logic [14:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        img_we,
  output logic        conv_w_we,
  output logic        conv_b_we,
  output logic        dense_w_we,
  output logic        dense_b_we,
  output logic        start,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [2:0]  last_type
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    TYPE    = 2'd1,
    PAYLOAD = 2'd2,
    CHECK   = 2'd3
  } state_t;

  localparam logic [14:0] IMG_LEN     = 15'(IMG_BYTES);
  localparam logic [14:0] CONV_W_LEN  = 15'(CONV_W_BYTES);
  localparam logic [14:0] CONV_B_LEN  = 15'(CONV_B_WORDS * 4);
  localparam logic [14:0] DENSE_W_LEN = 15'(DENSE_W_BYTES);
  localparam logic [14:0] DENSE_B_LEN = 15'(DENSE_B_WORDS * 4);

  // Payload length in bytes for a frame type (bias types carry 4 bytes per word).
  function automatic logic [14:0] payload_len(input logic [2:0] t);
    logic [14:0] len;
    case (t)
      3'd0:    len = IMG_LEN;
      3'd1:    len = CONV_W_LEN;
      3'd2:    len = CONV_B_LEN;
      3'd3:    len = DENSE_W_LEN;
      3'd4:    len = DENSE_B_LEN;
      default: len = 15'd1;
    endcase
    return len;
  endfunction

  function automatic logic is_bias(input logic [2:0] t);
    return (t == 3'd2) || (t == 3'd4);
  endfunction

  // One-hot strobe vector {img, conv_w, conv_b, dense_w, dense_b} for a frame type.
  function automatic logic [4:0] type_strobe(input logic [2:0] t);
    logic [4:0] s;
    case (t)
      3'd0:    s = 5'b10000;
      3'd1:    s = 5'b01000;
      3'd2:    s = 5'b00100;
      3'd3:    s = 5'b00010;
      3'd4:    s = 5'b00001;
      default: s = 5'b00000;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  state_t      state, state_nx;
  logic [2:0]  ftype, ftype_nx;
  logic [14:0] byte_cnt, byte_cnt_nx;
  logic [3:0]  word_cnt, word_cnt_nx;
  logic [1:0]  byte_idx, byte_idx_nx;
  logic [7:0]  sum, sum_nx;
  logic [23:0] word_buf, word_buf_nx;

  logic [4:0]  we_vec, we_nx;
  logic [14:0] addr_nx;
  logic [31:0] data_nx;
  logic        start_nx, ok_nx, err_nx;
  logic [2:0]  last_type_nx;
  logic        accept;

  assign in_ready   = rst_n & ~infer_busy;
  assign accept     = in_valid & in_ready;
  assign img_we     = we_vec[4];
  assign conv_w_we  = we_vec[3];
  assign conv_b_we  = we_vec[2];
  assign dense_w_we = we_vec[1];
  assign dense_b_we = we_vec[0];

  // Next-state, counter, checksum and registered-output decode; everything holds without an accepted byte.
  always_comb begin
    state_nx     = state;
    ftype_nx     = ftype;
    byte_cnt_nx  = byte_cnt;
    word_cnt_nx  = word_cnt;
    byte_idx_nx  = byte_idx;
    sum_nx       = sum;
    word_buf_nx  = word_buf;
    we_nx        = 5'b00000;
    addr_nx      = wr_addr;
    data_nx      = wr_data;
    start_nx     = 1'b0;
    ok_nx        = 1'b0;
    err_nx       = 1'b0;
    last_type_nx = last_type;
    if (accept) begin
      case (state)
        HUNT: begin
          if (in_data == SYNC_BYTE) begin
            state_nx = TYPE;
          end else begin
            state_nx = HUNT;
          end
        end
        TYPE: begin
          if (in_data <= 8'd4) begin
            ftype_nx    = in_data[2:0];
            byte_cnt_nx = 15'd0;
            word_cnt_nx = 4'd0;
            byte_idx_nx = 2'd0;
            sum_nx      = 8'd0;
            word_buf_nx = 24'd0;
            state_nx    = PAYLOAD;
          end else begin
            err_nx       = 1'b1;
            last_type_nx = in_data[2:0];
            state_nx     = HUNT;
          end
        end
        PAYLOAD: begin
          sum_nx      = sum8(sum, in_data);
          byte_cnt_nx = byte_cnt + 15'd1;
          if (is_bias(ftype)) begin
            byte_idx_nx = byte_idx + 2'd1;
            // Bias words assemble LSB-first; the fourth byte completes and commits the word.
            case (byte_idx)
              2'd0:    word_buf_nx[7:0]   = in_data;
              2'd1:    word_buf_nx[15:8]  = in_data;
              2'd2:    word_buf_nx[23:16] = in_data;
              default: begin
                we_nx       = type_strobe(ftype);
                addr_nx     = {11'd0, word_cnt};
                data_nx     = {in_data, word_buf};
                word_cnt_nx = word_cnt + 4'd1;
                word_buf_nx = 24'd0;
              end
            endcase
          end else begin
            we_nx   = type_strobe(ftype);
            addr_nx = byte_cnt;
            data_nx = {24'd0, in_data};
          end
          if (byte_cnt == payload_len(ftype) - 15'd1) begin
            state_nx = CHECK;
          end else begin
            state_nx = PAYLOAD;
          end
        end
        CHECK: begin
          last_type_nx = ftype;
          state_nx     = HUNT;
          if (in_data == sum) begin
            ok_nx    = 1'b1;
            start_nx = AUTO_START && (ftype == 3'd0);
          end else begin
            err_nx = 1'b1;
          end
        end
        default: state_nx = HUNT;
      endcase
    end else begin
      state_nx = state;
    end
  end

  // Frame state, counters and running checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      ftype    <= 3'd0;
      byte_cnt <= 15'd0;
      word_cnt <= 4'd0;
      byte_idx <= 2'd0;
      sum      <= 8'd0;
      word_buf <= 24'd0;
    end else begin
      state    <= state_nx;
      ftype    <= ftype_nx;
      byte_cnt <= byte_cnt_nx;
      word_cnt <= word_cnt_nx;
      byte_idx <= byte_idx_nx;
      sum      <= sum_nx;
      word_buf <= word_buf_nx;
    end
  end

  // Registered write port and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_vec    <= 5'b00000;
      wr_addr   <= 15'd0;
      wr_data   <= 32'd0;
      start     <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      last_type <= 3'd0;
    end else begin
      we_vec    <= we_nx;
      wr_addr   <= addr_nx;
      wr_data   <= data_nx;
      start     <= start_nx;
      frame_ok  <= ok_nx;
      frame_err <= err_nx;
      last_type <= last_type_nx;
    end
  end

endmodule

// File: tb/tb_model_loader.sv
// Directed bench for model_loader: sends framed payloads, checks every memory write
// against an expectation queue and the frame status pulses against hand-derived counts.
module tb_model_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        infer_busy = 1'b0;
  logic [14:0] wr_addr;
  logic [31:0] wr_data;
  logic        img_we, conv_w_we, conv_b_we, dense_w_we, dense_b_we;
  logic        start, frame_ok, frame_err;
  logic [2:0]  last_type;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  we;
    logic [14:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  int   wcnt[5] = '{default: 0};
  int   ok_cnt = 0, err_cnt = 0, start_cnt = 0, stall_writes = 0;
  logic stall_mon = 1'b0;

  always #5 clk = ~clk;

  model_loader dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .infer_busy(infer_busy), .wr_addr(wr_addr), .wr_data(wr_data), .img_we(img_we),
    .conv_w_we(conv_w_we), .conv_b_we(conv_b_we), .dense_w_we(dense_w_we),
    .dense_b_we(dense_b_we), .start(start), .frame_ok(frame_ok), .frame_err(frame_err),
    .last_type(last_type)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write and pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [4:0] v;
    wr_t e;
    if (rst_n) begin
      v = {img_we, conv_w_we, conv_b_we, dense_w_we, dense_b_we};
      if (stall_mon && v != 5'd0) stall_writes++;
      if (v != 5'd0) begin
        for (int t = 0; t < 5; t++) if (v[4-t]) wcnt[t]++;
        if (exp_q.size() == 0) begin
          check("unexpected_we", {27'd0, v}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("we", {27'd0, v}, {27'd0, e.we});
          check("addr", {17'd0, wr_addr}, {17'd0, e.addr});
          check("data", wr_data, e.data);
        end
      end
      if (frame_ok)  ok_cnt++;
      if (frame_err) err_cnt++;
      if (start)     start_cnt++;
    end
  end

  function automatic logic [7:0] pay(input logic [7:0] t, input int i);
    case (t)
      8'd0:    return 8'(i);
      8'd1:    return 8'(i * 3 + 1);
      default: return 8'(i * 7 + 3);
    endcase
  endfunction

  function automatic logic [31:0] bias_word(input logic [7:0] t, input int k);
    if (t == 8'd2) begin
      case (k)
        0:       return 32'h0000_0080;
        1:       return 32'hFFFF_FF80;
        2:       return 32'h1234_5678;
        default: return 32'h0000_0000;
      endcase
    end else begin
      return 32'h8000_0000 - 32'(k) * 32'h0001_0203;
    end
  endfunction

  task automatic send(input logic [7:0] b);
    int guard;
    guard = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_stall(input logic [7:0] next_byte);
    logic ready_seen;
    ready_seen = 1'b0;
    infer_busy = 1'b1;
    @(posedge clk);
    #1;
    stall_mon = 1'b1;
    in_data   = next_byte;
    in_valid  = 1'b1;
    for (int c = 0; c < 49; c++) begin
      @(negedge clk);
      if (in_ready) ready_seen = 1'b1;
    end
    check("stall_ready", {31'd0, ready_seen}, 32'd0);
    @(posedge clk);
    #1;
    stall_mon  = 1'b0;
    infer_busy = 1'b0;
    check("stall_writes", 32'(stall_writes), 32'd0);
  endtask

  task automatic do_abort();
    check("pending_we", {31'd0, dense_b_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {26'd0, img_we, conv_w_we, conv_b_we, dense_w_we, dense_b_we, start},
          32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] t, input int n, input logic [7:0] adj,
                            input int stall_at, input int abort_at);
    logic [7:0]  s, b;
    logic [31:0] w;
    wr_t         e;
    s = 8'd0;
    send(8'hA5);
    send(t);
    for (int i = 0; i < n; i++) begin
      if (t == 8'd2 || t == 8'd4) begin
        w = bias_word(t, i / 4);
        b = w[8*(i%4) +: 8];
        if (i % 4 == 3) begin
          e.we = 5'b10000 >> t; e.addr = 15'(i / 4); e.data = w;
          exp_q.push_back(e);
        end
      end else begin
        b = pay(t, i);
        e.we = 5'b10000 >> t; e.addr = 15'(i); e.data = {24'd0, b};
        exp_q.push_back(e);
      end
      send(b);
      s = s + b;
      if (i == stall_at) do_stall(pay(t, i + 1));
      if (i == abort_at) begin
        do_abort();
        return;
      end
    end
    send(s + adj);
    repeat (3) @(posedge clk);
    #1;
  endtask

  int ok0, err0, st0, w0, wt0;

  function automatic int wsum();
    return wcnt[0] + wcnt[1] + wcnt[2] + wcnt[3] + wcnt[4];
  endfunction

  task automatic snap(input int t);
    ok0 = ok_cnt; err0 = err_cnt; st0 = start_cnt; w0 = wcnt[t]; wt0 = wsum();
  endtask

  task automatic frame_result(input string tag, input int t, input int nw, input int ok,
                              input int err, input int st, input logic [2:0] lt);
    check({tag, "_writes"}, 32'(wcnt[t] - w0), 32'(nw));
    check({tag, "_all_writes"}, 32'(wsum() - wt0), 32'(nw));
    check({tag, "_ok"}, 32'(ok_cnt - ok0), 32'(ok));
    check({tag, "_err"}, 32'(err_cnt - err0), 32'(err));
    check({tag, "_start"}, 32'(start_cnt - st0), 32'(st));
    check({tag, "_last_type"}, {29'd0, last_type}, {29'd0, lt});
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1;
    check("rst_outputs", {15'd0, img_we, conv_w_we, conv_b_we, dense_w_we, dense_b_we, start,
                          frame_ok, frame_err, last_type, in_ready}, 32'd0);
    check("rst_addr_data", wr_data | {17'd0, wr_addr}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", {31'd0, in_ready}, 32'd1);

    snap(0);
    send_frame(8'd0, 784, 8'd0, -1, -1);
    frame_result("img", 0, 784, 1, 0, 1, 3'd0);

    snap(2);
    send_frame(8'd2, 16, 8'd0, -1, -1);
    frame_result("conv_b", 2, 4, 1, 0, 0, 3'd2);

    snap(1);
    send_frame(8'd1, 36, 8'd1, -1, -1);
    frame_result("conv_w_bad", 1, 36, 0, 1, 0, 3'd1);
    snap(1);
    send_frame(8'd1, 36, 8'd0, -1, -1);
    frame_result("conv_w_good", 1, 36, 1, 0, 0, 3'd1);

    snap(0);
    send(8'h00);
    send(8'h13);
    send(8'hA5);
    send(8'h07);
    repeat (3) @(posedge clk);
    #1;
    frame_result("bad_type", 0, 0, 0, 1, 0, 3'd7);

    snap(3);
    send_frame(8'd3, 27040, 8'd0, 1000, -1);
    frame_result("dense_w", 3, 27040, 1, 0, 0, 3'd3);

    send_frame(8'd4, 40, 8'd0, -1, 7);
    check("abort_last_type", {29'd0, last_type}, 32'd0);
    snap(4);
    send_frame(8'd4, 40, 8'd0, -1, -1);
    frame_result("dense_b", 4, 10, 1, 0, 0, 3'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
